// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding, FSM states, first illegal opcode.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_NOT  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SLT  = 4'h6,
    OP_EQ   = 4'h7,
    OP_SLTU = 4'h8,
    OP_SLL  = 4'h9,
    OP_SRL  = 4'hA,
    OP_SRA  = 4'hB,
    OP_MUL  = 4'hC
  } alu_op_e;

  // Every code from here upward is rejected with err=1.
  localparam logic [3:0] OP_FIRST_ILLEGAL = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per step.
// Latency: WIDTH steps after start; done is high during the final step.
// Backpressure: none; the owner holds off start until the previous product is taken.
// Ports: clk, rst_n, start (load a/b), step (advance one bit), a, b,
//        done (this step is the last), product (accumulator after this step).
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  import alu_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [SHW-1:0]     cnt;

  // Looks one step ahead so the owner can register the full product on the
  // same edge that retires the last bit.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = step && (cnt == SHW'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;  // wraps to 0 after WIDTH-1 (WIDTH is a power of two)
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: registers a result plus zf/nf/cf/of/err per accepted op; MUL is iterative.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 edges for MUL.
// Backpressure: result held in DONE until out_ready; a new op may be accepted on the consuming edge.
// Ports: clk, rst_n, in_valid/in_ready/in_a/in_b/in_op (request),
//        out_valid/out_ready/out_res/out_zf/out_nf/out_cf/out_of/out_err (response).
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zf,
  output logic             out_nf,
  output logic             out_cf,
  output logic             out_of,
  output logic             out_err
);
  import alu_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  alu_state_e         state, state_nxt;
  alu_op_e            op;
  logic               accept;
  logic               is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic               sub;
  logic [WIDTH-1:0]   b_x;
  logic [WIDTH:0]     sum;
  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   r_res;
  logic               r_zf, r_nf, r_cf, r_of, r_err;

  assign op     = alu_op_e'(in_op);
  assign is_mul = (op == OP_MUL);
  assign accept = in_valid && in_ready;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .step    (state == ST_BUSY),
    .a       (in_a),
    .b       (in_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = is_mul ? ST_BUSY : ST_DONE;
      ST_BUSY: if (mul_done) state_nxt = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          if (accept) state_nxt = is_mul ? ST_BUSY : ST_DONE;
          else        state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; in_ready looks at out_ready so a consumed result frees the slot in the same cycle.
  always_comb begin
    in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    out_valid = (state == ST_DONE);
  end

  // Single-cycle datapath, evaluated on the operands being accepted this cycle.
  always_comb begin
    sub   = (op == OP_SUB);
    b_x   = in_b ^ {WIDTH{sub}};
    sum   = {1'b0, in_a} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub};
    sh    = in_b[SHW-1:0];
    r_res = '0;
    r_cf  = 1'b0;
    r_of  = 1'b0;
    r_err = (in_op >= OP_FIRST_ILLEGAL);
    case (op)
      OP_ADD, OP_SUB: begin
        r_res = sum[WIDTH-1:0];
        r_cf  = sum[WIDTH];
        r_of  = (in_a[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_NOT:  r_res = ~in_a;
      OP_AND:  r_res = in_a & in_b;
      OP_OR:   r_res = in_a | in_b;
      OP_XOR:  r_res = in_a ^ in_b;
      OP_SLT:  r_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_EQ:   r_res = {{(WIDTH-1){1'b0}}, (in_a == in_b)};
      OP_SLTU: r_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OP_SLL:  r_res = in_a << sh;
      OP_SRL:  r_res = in_a >> sh;
      OP_SRA:  r_res = $signed(in_a) >>> sh;
      default: r_res = '0;  // MUL goes through the multiplier; illegal codes stay 0
    endcase
    r_zf = !r_err && (r_res == '0);
    r_nf = !r_err && r_res[WIDTH-1];
  end

  // Output registers: loaded on a single-cycle accept or on the final MUL step (never both).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_res <= '0;
      out_zf  <= 1'b0;
      out_nf  <= 1'b0;
      out_cf  <= 1'b0;
      out_of  <= 1'b0;
      out_err <= 1'b0;
    end else if (accept && !is_mul) begin
      out_res <= r_res;
      out_zf  <= r_zf;
      out_nf  <= r_nf;
      out_cf  <= r_cf;
      out_of  <= r_of;
      out_err <= r_err;
    end else if (mul_done) begin
      out_res <= mul_prod[WIDTH-1:0];
      out_zf  <= (mul_prod[WIDTH-1:0] == '0);
      out_nf  <= mul_prod[WIDTH-1];
      out_cf  <= 1'b0;
      out_of  <= |mul_prod[2*WIDTH-1:WIDTH];
      out_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=4 and WIDTH=8.
// Expected responses are queued on acceptance; monitors pop on each output handshake.
module tb_alu_seq;

  typedef struct packed {
    logic [7:0] res;
    logic zf, nf, cf, of, err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cnt4 = 0;
  int cnt8 = 0;

  logic       iv4 = 1'b0, ordy4 = 1'b1, ir4, ov4;
  logic [3:0] a4 = '0, b4 = '0, op4 = '0, res4;
  logic       zf4, nf4, cf4, of4, err4;

  logic       iv8 = 1'b0, ordy8 = 1'b1, ir8, ov8;
  logic [7:0] a8 = '0, b8 = '0, res8;
  logic [3:0] op8 = '0;
  logic       zf8, nf8, cf8, of8, err8;

  alu_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
    .in_op(op4), .out_valid(ov4), .out_ready(ordy4), .out_res(res4), .out_zf(zf4),
    .out_nf(nf4), .out_cf(cf4), .out_of(of4), .out_err(err4)
  );

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_op(op8), .out_valid(ov8), .out_ready(ordy8), .out_res(res8), .out_zf(zf8),
    .out_nf(nf8), .out_cf(cf8), .out_of(of8), .out_err(err8)
  );

  wire [12:0] act4 = {4'h0, res4, zf4, nf4, cf4, of4, err4};
  wire [12:0] act8 = {res8, zf8, nf8, cf8, of8, err8};

  exp_t q4[$];
  exp_t q8[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input logic [7:0] ai, input logic [7:0] bi);
    longint m, half, a, b, sa, sb, r, s;
    int sh;
    exp_t e;
    e    = '0;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    a    = longint'(ai) & m;
    b    = longint'(bi) & m;
    sa   = (a >= half) ? a - (m + 1) : a;
    sb   = (b >= half) ? b - (m + 1) : b;
    sh   = int'(b % w);
    r    = 0;
    case (op)
      4'h0: begin r = a + b; s = sa + sb; e.cf = (r > m);  e.of = (s >= half) || (s < -half); end
      4'h1: begin r = a - b; s = sa - sb; e.cf = (a >= b); e.of = (s >= half) || (s < -half); end
      4'h2: r = ~a;
      4'h3: r = a & b;
      4'h4: r = a | b;
      4'h5: r = a ^ b;
      4'h6: r = (sa < sb) ? 1 : 0;
      4'h7: r = (a == b) ? 1 : 0;
      4'h8: r = (a < b) ? 1 : 0;
      4'h9: r = a << sh;
      4'hA: r = a >> sh;
      4'hB: r = sa >>> sh;
      4'hC: begin r = a * b; e.of = ((r >> w) != 0); end
      default: begin r = 0; e.err = 1'b1; end
    endcase
    r     = r & m;
    e.res = 8'(r);
    if (!e.err) begin
      e.zf = (r == 0);
      e.nf = ((r >> (w - 1)) & 1) != 0;
    end
    return e;
  endfunction

  // Monitors: one pop per output handshake.
  always @(negedge clk) begin
    if (rst_n && ov4 && ordy4) begin
      cnt4++;
      if (q4.size() == 0) begin
        checks++; fails++;
        $display("FAIL out4 unexpected: got 0x%0h with no pending expectation", act4);
      end else check("out4 result", 64'(act4), 64'(q4.pop_front()));
    end
    if (rst_n && ov8 && ordy8) begin
      cnt8++;
      if (q8.size() == 0) begin
        checks++; fails++;
        $display("FAIL out8 unexpected: got 0x%0h with no pending expectation", act8);
      end else check("out8 result", 64'(act8), 64'(q8.pop_front()));
    end
  end

  task automatic drive(input int w, input logic v, input logic [3:0] op,
                       input logic [7:0] a, input logic [7:0] b);
    if (w == 4) begin iv4 = v; op4 = op; a4 = a[3:0]; b4 = b[3:0]; end
    else        begin iv8 = v; op8 = op; a8 = a;      b8 = b;      end
  endtask

  function automatic logic rdy(input int w);
    return (w == 4) ? ir4 : ir8;
  endfunction

  task automatic push(input int w, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    if (w == 4) q4.push_back(model(4, op, a, b));
    else        q8.push_back(model(8, op, a, b));
  endtask

  // Called just after a rising edge; returns just after the accepting edge,
  // with the inputs scrambled to show they were captured.
  task automatic issue(input int w, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    drive(w, 1'b1, op, a, b);
    @(negedge clk);
    while (!rdy(w) && n < 50) begin @(negedge clk); n++; end
    if (!rdy(w)) begin
      checks++; fails++;
      $display("FAIL accept timeout w%0d: in_ready=0, expected 1", w);
      drive(w, 1'b0, op, a, b);
      return;
    end
    push(w, op, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, 4'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic stream(input int w);
    logic [3:0] op;
    logic       rdy_ok;
    int         c0;
    rdy_ok = 1'b1;
    c0 = (w == 4) ? cnt4 : cnt8;
    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(0, 14));
      if (op == 4'hC) op = 4'h0;
      drive(w, 1'b1, op, 8'($urandom), 8'($urandom));
      @(negedge clk);
      if (!rdy(w)) rdy_ok = 1'b0;
      else push(w, op, (w == 4) ? {4'h0, a4} : a8, (w == 4) ? {4'h0, b4} : b8);
      @(posedge clk); #1;
    end
    drive(w, 1'b0, 4'h0, 8'h0, 8'h0);
    @(posedge clk); #1;
    check($sformatf("stream%0d in_ready held", w), 64'(rdy_ok), 64'(1));
    check($sformatf("stream%0d result count", w), 64'(((w == 4) ? cnt4 : cnt8) - c0), 64'(16));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic busy_ok, stale;
    exp_t e;

    // Reset values
    repeat (2) @(negedge clk);
    check("reset4 in_ready", 64'(ir4), 64'(1));
    check("reset4 out_valid", 64'(ov4), 64'(0));
    check("reset4 res+flags", 64'(act4), 64'(0));
    check("reset8 in_ready", 64'(ir8), 64'(1));
    check("reset8 out_valid", 64'(ov8), 64'(0));
    check("reset8 res+flags", 64'(act8), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // WIDTH=4 directed vectors
    issue(4, 4'h0, 8'h7, 8'h1);
    issue(4, 4'h1, 8'h3, 8'h5);
    issue(4, 4'h1, 8'h5, 8'h5);
    issue(4, 4'h6, 8'hF, 8'h1);
    issue(4, 4'h8, 8'hF, 8'h1);
    issue(4, 4'hB, 8'h8, 8'h2);
    issue(4, 4'hA, 8'h8, 8'h2);
    issue(4, 4'hE, 8'h3, 8'h3);
    wait_cycles(3);

    // WIDTH=8 MUL latency: accepting edge counts as edge 1
    issue(8, 4'hC, 8'h10, 8'h11);
    n = 1;
    busy_ok = 1'b1;
    @(negedge clk);
    while (!ov8 && n < 50) begin
      if (ir8) busy_ok = 1'b0;
      @(posedge clk); n++;
      @(negedge clk);
    end
    check("mul latency edges", 64'(n), 64'(9));
    check("mul in_ready low while busy", 64'(busy_ok), 64'(1));
    wait_cycles(2);

    // Backpressure in DONE
    ordy8 = 1'b0;
    issue(8, 4'h0, 8'h22, 8'h33);
    e = model(8, 4'h0, 8'h22, 8'h33);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp out_valid held", 64'(ov8), 64'(1));
      check("bp in_ready low", 64'(ir8), 64'(0));
      check("bp outputs stable", 64'(act8), 64'(e));
    end
    @(posedge clk); #1;
    ordy8 = 1'b1;
    issue(8, 4'h0, 8'h01, 8'h01);
    @(negedge clk);
    check("bp consume+accept out_valid", 64'(ov8), 64'(1));
    check("bp consume+accept res", 64'(res8), 64'(2));
    wait_cycles(2);

    // Reset in the middle of a MUL
    issue(8, 4'hC, 8'hFF, 8'hFF);
    wait_cycles(3);
    rst_n = 1'b0;
    wait_cycles(2);
    q8.delete();
    @(negedge clk);
    check("mid-mul reset in_ready", 64'(ir8), 64'(1));
    check("mid-mul reset out_valid", 64'(ov8), 64'(0));
    check("mid-mul reset res", 64'(res8), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    stale = 1'b0;
    repeat (12) begin
      @(negedge clk);
      stale = stale | ov8;
    end
    check("no stale result after reset", 64'(stale), 64'(0));
    @(posedge clk); #1;

    // Back-to-back random single-cycle ops
    stream(4);
    stream(8);

    n = 0;
    while ((q4.size() + q8.size()) != 0 && n < 50) begin @(posedge clk); n++; end
    check("scoreboard drained", 64'(q4.size() + q8.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked ALU that succeeds the fixed 4-bit combinational ALU in the NPC datapath. It registers operands and opcode on a valid/ready input handshake and returns a registered result with status flags on a valid/ready output handshake. Single-cycle ops complete in one cycle; unsigned multiply runs iteratively over WIDTH cycles. The result feeds the sign/magnitude 7-segment display path and, later, the EXU.

## Interface
- WIDTH, 8: operand/result width; a power of two, at least 4.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept.
- in_a, in_b  in  WIDTH  operands.
- in_op  in  4  opcode (alu_pkg::alu_op_e).
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- out_res  out  WIDTH  result.
- out_zf, out_nf, out_cf, out_of, out_err  out  1 each  zero, negative, carry, overflow, illegal-op flags.

## Operation
- Opcodes 0x0-0x7 keep their legacy encodings:
  - 0 ADD, 1 SUB, 2 NOT(a), 3 AND, 4 OR, 5 XOR.
  - 6 SLT: signed a<b gives 1, else 0, zero-extended.
  - 7 EQ: 1 when a==b.
- Opcodes 0x8-0xC are new:
  - 8 SLTU.
  - 9 SLL, A SRL, B SRA: shift amount is in_b[SHW-1:0].
  - C MUL: low WIDTH bits of the unsigned product.
- Opcodes D-F are illegal: res=0, err=1, all other flags 0.
- ADD and SUB are computed as a + (b^{W{sub}}) + sub in WIDTH+1 bits.
  - cf = bit WIDTH of that sum. For SUB, cf=1 means no borrow.
  - of = signed overflow: operand signs (after inversion) are equal and differ from the result sign.
- MUL: of=1 when the upper WIDTH bits of the 2·WIDTH product are non-zero; cf=0.
- All other ops: cf=0, of=0.
- zf = (res==0) and nf = res[WIDTH-1] for every legal op.
- FSM states:
  - IDLE: in_ready=1. On accept, go to DONE for a non-MUL op, or to BUSY for MUL.
  - BUSY: in_ready=0. Performs one shift-add step per cycle using a counter 0..WIDTH-1. On the step with counter==WIDTH-1, go to DONE.
  - DONE: out_valid=1 and outputs stay stable. If out_ready=1, leave DONE: go to IDLE, or accept a new op in the same cycle (see Timing).
- Operands are captured at acceptance. Changes on in_a/in_b/in_op afterwards have no effect.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_res=0, all flags 0, MUL counter=0.
- Reset asserted mid-BUSY or in DONE aborts the operation. The result is discarded and never presented.
- Accept = in_valid && in_ready, sampled at a rising edge.
- Non-MUL latency: out_valid=1 in the cycle after the accepting edge.
- MUL latency: out_valid=1 after WIDTH+1 edges counted from and including the accepting edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready). A new op can be accepted in the same cycle the old result is consumed, which gives back-to-back throughput of 1 op/cycle for non-MUL ops.
- In DONE with out_ready=0, out_* stay stable indefinitely.
- Simultaneous consume and accept of a non-MUL op: state stays DONE and the outputs update to the new result on that edge.
- Simultaneous consume and accept of a MUL op: go to BUSY and drop out_valid on that edge.
- No combinational path from in_* to out_*.

## Structure
- Package alu_pkg holds:
  - typedef enum logic [3:0] alu_op_e with OP_ADD..OP_MUL values as above.
  - A localparam for the first illegal code (4'hD).
- Sub-module alu_mul_iter holds the iterative multiplier:
  - Registers: multiplicand, multiplier, 2·WIDTH accumulator, counter.
  - Interface: start, done, product.
  - It is instantiated once. alu_seq owns the FSM, the single-cycle datapath, flag generation and the output registers.

## Test plan
- Reset: hold rst_n=0 mid-MUL for 2 cycles, release -> in_ready=1, out_valid=0, out_res=0, no stale result appears afterwards.
- WIDTH=4:
  - ADD 7+1 -> res=8, nf=1, of=1, cf=0.
  - SUB 3-5 -> res=0xE, cf=0, nf=1.
  - SUB 5-5 -> res=0, zf=1, cf=1.
- WIDTH=4:
  - SLT 0xF,0x1 -> 1.
  - SLTU 0xF,0x1 -> 0.
  - SRA 0x8 by 2 -> 0xE.
  - SRL 0x8 by 2 -> 0x2.
  - Opcode 0xE -> res=0, err=1.
- WIDTH=8, MUL 0x10×0x11:
  - out_valid rises exactly 9 edges after acceptance.
  - res=0x10, of=1.
  - in_ready=0 throughout BUSY.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0. Raise out_ready with in_valid=1 (ADD 1+1) -> next cycle res=2, out_valid stays 1.
- Streaming: 16 random non-MUL ops with in_valid and out_ready tied high -> one result per cycle, all matching the reference model.
